// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered palette sprite ROM between NUM_REQ draw engines.
// Returns the ROM colour with a one-hot owner tag, a transparency flag and an optional bounded row lock.
module sprite_rom_arbiter #(
  parameter int                NUM_REQ     = 2,
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 24,
  parameter int                ROM_LATENCY = 2,
  parameter int                MAX_LOCK    = 16,
  parameter logic [DATA_W-1:0] TRANSP_KEY  = DATA_W'(24'hFF0000)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_transparent
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]         lock_state;
  logic [IDX_W-1:0]   lock_owner;
  logic [CNT_W-1:0]   lock_cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   rr_next;
  logic               gnt_any;
  logic               lock_hold;
  logic               accept;
  logic [NUM_REQ-1:0] tag_pipe [ROM_LATENCY+1];

  // The lock only holds the ROM while its owner is still requesting.
  assign lock_hold = (lock_state == ST_LOCKED) && req[lock_owner];

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (Reset_n) begin
      if (lock_hold) begin
        gnt_idx = lock_owner;
        gnt_any = 1'b1;
      end else begin
        // Descending scan: the last hit is the one closest to rr_ptr.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            gnt_any = 1'b1;
          end
        end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
  end

  assign accept  = |(req & gnt);
  assign rr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr     <= '0;
      rom_addr   <= '0;
      lock_state <= ST_UNLOCKED;
      lock_owner <= '0;
      lock_cnt   <= '0;
    end else begin
      if (accept) begin
        rom_addr <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        rr_ptr   <= rr_next;
      end

      if (accept && lock_hold) begin
        if (req_lock[lock_owner] && (lock_cnt != CNT_W'(MAX_LOCK - 1))) begin
          lock_cnt <= lock_cnt + 1'b1;
        end else begin
          lock_state <= ST_UNLOCKED;
          lock_cnt   <= '0;
        end
      end else if (accept && LOCK_EN && req_lock[gnt_idx]) begin
        lock_state <= ST_LOCKED;
        lock_owner <= gnt_idx;
        lock_cnt   <= CNT_W'(1);
      end else begin
        lock_state <= ST_UNLOCKED;
        lock_cnt   <= '0;
      end
    end
  end

  // The ROM cannot stall, so the owner tag shifts every cycle alongside the read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the tag pipe is reset so in-flight reads never surface as responses after reset.
      for (int i = 0; i <= ROM_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= accept ? gnt : '0;
      for (int i = 1; i <= ROM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign rsp_valid       = tag_pipe[ROM_LATENCY];
  assign rsp_data        = rom_data;
  assign rsp_transparent = (|rsp_valid) && (rom_data == TRANSP_KEY);

endmodule
